// File: rtl/regfile_port_sched.sv
// Write-port scheduler and busy scoreboard for the 8x16 register file.
// Round-robin grants share the single write port; busy bits flag pending producers.
module regfile_port_sched #(
   parameter int N_REQ  = 3,
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [N_REQ-1:0]           req_valid,
   input  logic [N_REQ*ADDR_W-1:0]    req_addr,
   input  logic [N_REQ*DATA_W-1:0]    req_data,
   output logic [N_REQ-1:0]           req_ready,
   input  logic                       rsv_valid,
   input  logic [ADDR_W-1:0]          rsv_addr,
   input  logic [ADDR_W-1:0]          rs0,
   input  logic [ADDR_W-1:0]          rs1,
   output logic                       hazard,
   output logic [(1<<ADDR_W)-1:0]     busy,
   output logic [ADDR_W-1:0]          rd,
   output logic [DATA_W-1:0]          busD_in,
   output logic                       r_latch,
   output logic                       rsv_err
);

   localparam int              PTR_W   = $clog2(N_REQ);
   localparam int              NREG    = 1 << ADDR_W;
   localparam logic [PTR_W:0]  N_REQ_L = (PTR_W+1)'(N_REQ);

   logic [PTR_W-1:0]  ptr_q, ptr_d;
   logic [ADDR_W-1:0] rd_q, rd_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              latch_q, latch_d;
   logic [NREG-1:0]   busy_q, busy_d;
   logic              err_q, err_d;

   logic              found_s;
   logic [PTR_W-1:0]  gnt_idx_s;
   logic [PTR_W-1:0]  cand_s;
   logic [N_REQ-1:0]  grant_s;
   logic              xfer_s;

   function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                 input logic [PTR_W-1:0] ofs);
      logic [PTR_W:0] sum;
      sum = {1'b0, base} + {1'b0, ofs};
      sum = (sum >= N_REQ_L) ? (sum - N_REQ_L) : sum;
      return sum[PTR_W-1:0];
   endfunction

   // Round-robin search for the first valid requester at or after ptr.
   always_comb begin
      found_s   = 1'b0;
      gnt_idx_s = '0;
      cand_s    = '0;
      for (int k = 0; k < N_REQ; k++) begin
         cand_s = wrap_add(ptr_q, PTR_W'(k));
         if (!found_s && req_valid[cand_s]) begin
            found_s   = 1'b1;
            gnt_idx_s = cand_s;
         end else begin
            found_s   = found_s;
         end
      end
   end

   // One-hot grant, suppressed while reset is held.
   always_comb begin
      grant_s = '0;
      if (rst_n && found_s) begin
         grant_s[gnt_idx_s] = 1'b1;
      end else begin
         grant_s = '0;
      end
   end

   assign xfer_s = rst_n & found_s;

   // Next state: transfer capture, pointer advance and scoreboard update.
   always_comb begin
      ptr_d   = ptr_q;
      rd_d    = rd_q;
      data_d  = data_q;
      latch_d = 1'b0;
      busy_d  = busy_q;
      err_d   = err_q;
      if (xfer_s) begin
         ptr_d   = wrap_add(gnt_idx_s, PTR_W'(1));
         rd_d    = req_addr[gnt_idx_s*ADDR_W +: ADDR_W];
         data_d  = req_data[gnt_idx_s*DATA_W +: DATA_W];
         latch_d = 1'b1;
      end else begin
         latch_d = 1'b0;
      end
      // Clear first so a same-edge reserve of the same register wins.
      if (latch_q) begin
         busy_d[rd_q] = 1'b0;
      end else begin
         busy_d = busy_d;
      end
      if (rsv_valid) begin
         busy_d[rsv_addr] = 1'b1;
         if (busy_q[rsv_addr] && !(latch_q && (rd_q == rsv_addr))) begin
            err_d = 1'b1;
         end else begin
            err_d = err_d;
         end
      end else begin
         busy_d = busy_d;
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr_q   <= '0;
         rd_q    <= '0;
         data_q  <= '0;
         latch_q <= 1'b0;
         busy_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         ptr_q   <= ptr_d;
         rd_q    <= rd_d;
         data_q  <= data_d;
         latch_q <= latch_d;
         busy_q  <= busy_d;
         err_q   <= err_d;
      end
   end

   assign req_ready = grant_s;
   assign hazard    = busy_q[rs0] | busy_q[rs1];
   assign busy      = busy_q;
   assign rd        = rd_q;
   assign busD_in   = data_q;
   assign r_latch   = latch_q;
   assign rsv_err   = err_q;

endmodule
